// File: rtl/fir_cap_pkg.sv
// Shared types and helpers for the FIR output capture stage.
// The saturating narrow (sat_o) is only used when FIR_CAP_SAT_EN is defined.
package fir_cap_pkg;

    localparam int Y_W = 16;
    localparam int O_W = 8;
    localparam int S_W = Y_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2
    } cap_state_e;

    // Clamp a rescaled 17-bit value into the signed 8-bit output range.
    function automatic logic signed [O_W-1:0] sat_o(input logic signed [S_W-1:0] v);
        if (v > 17'sd127) begin
            return 8'sd127;
        end else if (v < -17'sd128) begin
            return -8'sd128;
        end else begin
            return O_W'(v);
        end
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read and synchronous reset.
// A push while full is still accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     Rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_reg [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          pop_fire;
    logic          push_ok;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == CW'(DEPTH));
    assign pop_fire  = pop & ~empty;
    assign push_ok   = push & (~full | pop_fire);
    assign count     = count_reg;
    // Empty FIFO presents zero rather than a stale entry.
    assign head_data = empty ? '0 : mem_reg[rd_ptr_reg];

    // Storage write; contents need no reset because the pointers flush it.
    always_ff @(posedge clk) begin
        if (!Rst && push_ok) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (Rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_fire) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_fire})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/fir_out_capture.sv
// Capture stage for the serial-DA FIR: samples Yn a fixed delay after each
// x_stb, rescales with round-half-up to 8 bits and queues the result.
// Build option FIR_CAP_SAT_EN: saturate the 8-bit result instead of wrapping.
module fir_out_capture
    import fir_cap_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int CAP_DELAY = 8,
    parameter int SHIFT     = 7
) (
    input  logic                        clk,
    input  logic                        Rst,
    input  logic                        x_stb,
    input  logic signed [Y_W-1:0]       Yn,
    output logic signed [O_W-1:0]       out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        overflow,
    output logic                        miss
);

    localparam logic [3:0]            CNT_LOAD = 4'(CAP_DELAY - 1);
    localparam logic signed [S_W-1:0] RND      = 17'sd1 <<< (SHIFT - 1);

    cap_state_e            state_reg, state_next;
    logic [3:0]            cnt_reg, cnt_next;
    logic signed [Y_W-1:0] cap_reg;
    logic                  cap_load;
    logic                  push;
    logic                  miss_set;
    logic                  overflow_reg;
    logic                  miss_reg;
    logic signed [S_W-1:0] s17;
    logic signed [S_W-1:0] q17;
    logic [O_W-1:0]        push_data;
    logic [O_W-1:0]        head_data;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push_drop;

    // Next-state logic: wait CAP_DELAY clocks, capture, then push for one cycle.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        cap_load   = 1'b0;
        push       = 1'b0;
        miss_set   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (x_stb) begin
                    state_next = WAIT;
                    cnt_next   = CNT_LOAD;
                end
            end
            WAIT: begin
                miss_set = x_stb;
                if (cnt_reg == 4'd0) begin
                    cap_load   = 1'b1;
                    state_next = CAPTURE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            CAPTURE: begin
                push = 1'b1;
                if (x_stb) begin
                    state_next = WAIT;
                    cnt_next   = CNT_LOAD;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, delay counter, captured sample and sticky flags.
    always_ff @(posedge clk) begin
        if (Rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= 4'd0;
            cap_reg      <= '0;
            overflow_reg <= 1'b0;
            miss_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            if (cap_load) begin
                cap_reg <= Yn;
            end
            overflow_reg <= overflow_reg | push_drop;
            miss_reg     <= miss_reg | miss_set;
        end
    end

    // Round-half-up rescale in 17 bits so the rounding offset cannot overflow.
    assign s17 = {cap_reg[Y_W-1], cap_reg} + RND;
    assign q17 = s17 >>> SHIFT;

`ifdef FIR_CAP_SAT_EN
    assign push_data = sat_o(q17);
`else
    assign push_data = O_W'(q17);
`endif

    // A capture is lost only when the FIFO is full and nothing leaves this cycle.
    assign push_drop = push & fifo_full & ~(out_valid & out_ready);

    sync_fifo #(
        .W     (O_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .Rst       (Rst),
        .push      (push),
        .push_data (push_data),
        .pop       (out_ready),
        .head_data (head_data),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid = ~fifo_empty;
    assign out_data  = head_data;
    assign overflow  = overflow_reg;
    assign miss      = miss_reg;

endmodule

// File: tb/tb_fir_out_capture.sv
// Scoreboard bench for fir_out_capture: a cycle-level reference model pushes
// expected samples into a queue; a negedge monitor pops and compares them.
module tb_fir_out_capture;

    localparam int DEPTH     = 8;
    localparam int CAP_DELAY = 8;
    localparam int SHIFT     = 7;
    localparam int CW        = $clog2(DEPTH) + 1;

    logic                clk = 1'b0;
    logic                Rst = 1'b1;
    logic                x_stb = 1'b0;
    logic signed [15:0]  Yn = '0;
    logic signed [7:0]   out_data;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [CW-1:0]       count;
    logic                overflow;
    logic                miss;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int                 edge_n    = 0;
    bit                 t0_valid  = 0;
    int                 t0        = 0;
    int                 push_edge = -1;
    logic signed [7:0]  push_val  = '0;
    int                 mcount    = 0;
    bit                 movf      = 0;
    bit                 mmiss     = 0;
    logic signed [7:0]  exp_q [$];
    bit                 mon_en    = 0;

    fir_out_capture #(
        .DEPTH     (DEPTH),
        .CAP_DELAY (CAP_DELAY),
        .SHIFT     (SHIFT)
    ) dut (
        .clk       (clk),
        .Rst       (Rst),
        .x_stb     (x_stb),
        .Yn        (Yn),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow),
        .miss      (miss)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, $signed(got), $signed(exp), $time);
        end
    endtask

    // Scaled value by plain arithmetic: floor((y + 2^(S-1)) / 2^S), then narrow.
    function automatic logic signed [7:0] ref_scale(input int y);
        int d = 1 << SHIFT;
        int s = y + d / 2;
        int q;
        if (s >= 0) q = s / d;
        else        q = -((-s + d - 1) / d);
`ifdef FIR_CAP_SAT_EN
        if (q > 127)  q = 127;
        if (q < -128) q = -128;
`endif
        return 8'(q);
    endfunction

    // Apply the specification's rules for one rising edge using the driven inputs.
    task automatic model_edge();
        bit pop;
        edge_n++;
        if (Rst) begin
            t0_valid  = 0;
            push_edge = -1;
            mcount    = 0;
            movf      = 0;
            mmiss     = 0;
            exp_q.delete();
            return;
        end
        pop = (mcount > 0) && out_ready;
        if (push_edge == edge_n) begin
            if (mcount < DEPTH || pop) begin
                exp_q.push_back(push_val);
                mcount++;
            end else begin
                movf = 1;
            end
        end
        if (pop) mcount--;
        if (t0_valid && edge_n == t0 + CAP_DELAY) begin
            push_val  = ref_scale(int'(Yn));
            push_edge = edge_n + 1;
        end
        if (x_stb) begin
            if (t0_valid && edge_n > t0 && edge_n <= t0 + CAP_DELAY) mmiss = 1;
            else begin
                t0       = edge_n;
                t0_valid = 1;
            end
        end
    endtask

    task automatic step(input logic stb, input logic signed [15:0] y,
                        input logic rdy, input logic rst);
        #1;
        x_stb = stb; Yn = y; out_ready = rdy; Rst = rst;
        @(posedge clk);
        model_edge();
    endtask

    // One strobe followed by CAP_DELAY quiet cycles: the minimum legal period.
    task automatic period(input logic signed [15:0] y, input logic rdy);
        step(1'b1, y, rdy, 1'b0);
        repeat (CAP_DELAY) step(1'b0, y, rdy, 1'b0);
    endtask

    // Monitor: compares flags, occupancy and popped data once per cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            logic signed [7:0] e;
            chk("out_valid", 32'(out_valid), 32'(mcount > 0));
            chk("count", 32'(count), 32'(mcount));
            chk("overflow", 32'(overflow), 32'(movf));
            chk("miss", 32'(miss), 32'(mmiss));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", 32'(1), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", 32'(out_data), 32'(e));
                end
            end
        end
    end

    initial begin
        // Reset
        step(1'b0, 16'sd0, 1'b0, 1'b1);
        step(1'b0, 16'sd0, 1'b0, 1'b1);
        #2;
        chk("rst_out_data", 32'(out_data), 32'(0));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_count", 32'(count), 32'(0));
        mon_en = 1;

        // Rounding: output appears on the 9th edge after the strobe
        step(1'b1, 16'sd12800, 1'b0, 1'b0);
        repeat (CAP_DELAY) step(1'b0, 16'sd12800, 1'b0, 1'b0);
        #2 chk("round_not_yet", 32'(out_valid), 32'(0));
        step(1'b0, 16'sd12800, 1'b0, 1'b0);
        #2 chk("round_pos", 32'(out_data), 32'(ref_scale(12800)));
        step(1'b0, 16'sd0, 1'b1, 1'b0);
        foreach (exp_q[i]) ; // queue is drained by the monitor
        period(-16'sd12800, 1'b0);
        step(1'b0, 16'sd0, 1'b0, 1'b0);
        #2 chk("round_neg", 32'(out_data), 32'(ref_scale(-12800)));
        step(1'b0, 16'sd0, 1'b1, 1'b0);
        period(16'sd32767, 1'b1);
        period(-16'sd32768, 1'b1);
        repeat (3) step(1'b0, 16'sd0, 1'b1, 1'b0);

        // Stream at the minimum period
        period(16'sd128, 1'b1);
        period(16'sd256, 1'b1);
        period(16'sd384, 1'b1);
        repeat (3) step(1'b0, 16'sd0, 1'b1, 1'b0);

        // Overflow: nine captures into an 8-entry FIFO with no consumer
        for (int i = 0; i < 9; i++) period(16'(128 * (i + 10)), 1'b0);
        step(1'b0, 16'sd0, 1'b0, 1'b0);
        #2;
        chk("ovf_count", 32'(count), 32'(DEPTH));
        chk("ovf_flag", 32'(overflow), 32'(1));
        repeat (10) step(1'b0, 16'sd0, 1'b1, 1'b0);

        // Full FIFO with a pop in the push cycle
        step(1'b0, 16'sd0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) period(16'(-128 * (i + 1)), 1'b0);
        step(1'b0, 16'sd0, 1'b1, 1'b0);
        step(1'b0, 16'sd0, 1'b0, 1'b0);
        #2;
        chk("fullpop_count", 32'(count), 32'(DEPTH));
        chk("fullpop_ovf", 32'(overflow), 32'(0));
        repeat (10) step(1'b0, 16'sd0, 1'b1, 1'b0);

        // Retrigger at 4-cycle spacing: one capture, miss set
        step(1'b0, 16'sd0, 1'b0, 1'b1);
        step(1'b1, 16'sd640, 1'b0, 1'b0);
        repeat (3) step(1'b0, 16'sd640, 1'b0, 1'b0);
        step(1'b1, 16'sd640, 1'b0, 1'b0);
        repeat (8) step(1'b0, 16'sd640, 1'b0, 1'b0);
        #2;
        chk("retrig_miss", 32'(miss), 32'(1));
        chk("retrig_count", 32'(count), 32'(1));

        // Reset during WAIT abandons the capture and clears everything
        step(1'b1, 16'sd1280, 1'b0, 1'b0);
        repeat (3) step(1'b0, 16'sd1280, 1'b0, 1'b0);
        step(1'b0, 16'sd1280, 1'b0, 1'b1);
        #2;
        chk("rstw_out_data", 32'(out_data), 32'(0));
        chk("rstw_miss", 32'(miss), 32'(0));
        chk("rstw_count", 32'(count), 32'(0));
        repeat (12) step(1'b0, 16'sd1280, 1'b0, 1'b0);
        #2 chk("rstw_no_push", 32'(count), 32'(0));

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 5) == 0), 16'($urandom), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 399) == 0));
        end
        repeat (12) step(1'b0, 16'sd0, 1'b1, 1'b0);
        #2;
        chk("final_drain", 32'(exp_q.size()), 32'(mcount));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
